// File: rtl/edsac_mem_pkg.sv
// Shared constants, state encoding and address layout for the
// mercury-delay-line store sequencer (optional TANK_SYNC_CHECK_EN).
package edsac_mem_pkg;

    localparam int DIGITS  = 36;
    localparam int WORDS   = 16;
    localparam int TANKS   = 32;
    localparam int DIGIT_W = $clog2(DIGITS);
    localparam int MINOR_W = $clog2(WORDS);
    localparam int TANK_W  = $clog2(TANKS);
    localparam int ADDR_W  = TANK_W + MINOR_W + 1;

    localparam int ADDR_ODD_BIT  = 0;
    localparam int ADDR_WORD_LSB = 1;
    localparam int ADDR_TANK_LSB = ADDR_WORD_LSB + MINOR_W;

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} seq_state_t;

    // First digit of the gated window for the requested word shape.
    function automatic logic [DIGIT_W-1:0] win_first(
        input logic lng,
        input logic odd
    );
        return (!lng && odd) ? DIGIT_W'(DIGITS/2) : '0;
    endfunction

    // Last digit of the gated window for the requested word shape.
    function automatic logic [DIGIT_W-1:0] win_last(
        input logic lng,
        input logic odd
    );
        return (!lng && !odd) ? DIGIT_W'(DIGITS/2 - 1)
                              : DIGIT_W'(DIGITS - 1);
    endfunction

endpackage

// File: rtl/tank_position_counter.sv
// Digit and minor-cycle position of the circulating words, resynced by d0.
// TANK_SYNC_CHECK_EN adds a sticky sync_err flag for d0 timing slips.
module tank_position_counter
    import edsac_mem_pkg::*;
(
    input  logic               clk,
    input  logic               reset_neg,
    input  logic               d0,
`ifdef TANK_SYNC_CHECK_EN
    output logic               sync_err,
`endif
    output logic [MINOR_W-1:0] minor,
    output logic [DIGIT_W-1:0] digit
);

    logic [DIGIT_W-1:0] digit_q;
    logic [MINOR_W-1:0] minor_q;
    logic               wrap;

    assign wrap  = (digit_q == DIGIT_W'(DIGITS - 1));
    assign digit = digit_q;
    assign minor = minor_q;

    // Digit advances each clock; d0 or the natural wrap return it to 0,
    // and only the natural end of a minor cycle steps the word position.
    always_ff @(posedge clk or negedge reset_neg) begin
        if (!reset_neg) begin
            digit_q <= '0;
            minor_q <= '0;
        end else begin
            if (d0 || wrap) begin
                digit_q <= '0;
            end else begin
                digit_q <= digit_q + DIGIT_W'(1);
            end
            if (wrap) begin
                if (minor_q == MINOR_W'(WORDS - 1)) begin
                    minor_q <= '0;
                end else begin
                    minor_q <= minor_q + MINOR_W'(1);
                end
            end
        end
    end

`ifdef TANK_SYNC_CHECK_EN
    logic sync_q;

    assign sync_err = sync_q;

    // Remember any d0 that lands away from the last digit.
    always_ff @(posedge clk or negedge reset_neg) begin
        if (!reset_neg) begin
            sync_q <= 1'b0;
        end else if (d0 && !wrap) begin
            sync_q <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/tank_access_sequencer.sv
// Serialises store requests and opens the tank gate for one word window.
// TANK_SYNC_CHECK_EN exposes the position counter's sync_err flag.
module tank_access_sequencer
    import edsac_mem_pkg::*;
(
    input  logic               clk,
    input  logic               reset_neg,
    input  logic               d0,
    input  logic               req,
    input  logic               req_wr,
    input  logic               req_long,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic               abort,
    output logic               ack,
    output logic               busy,
    output logic [TANK_W-1:0]  tank_sel,
    output logic               rd_gate,
    output logic               wr_gate,
    output logic               word_done,
    output logic [MINOR_W-1:0] minor,
`ifdef TANK_SYNC_CHECK_EN
    output logic               sync_err,
`endif
    output logic [DIGIT_W-1:0] digit
);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic               load;
    logic               ack_q;
    logic               wr_q;
    logic               long_q;
    logic               odd_q;
    logic [MINOR_W-1:0] word_q;
    logic [TANK_W-1:0]  tank_q;
    logic [DIGIT_W-1:0] first;
    logic [DIGIT_W-1:0] last;
    logic               in_win;
    logic               hit;
    logic               gate;

    tank_position_counter u_pos (
        .clk       (clk),
        .reset_neg (reset_neg),
        .d0        (d0),
`ifdef TANK_SYNC_CHECK_EN
        .sync_err  (sync_err),
`endif
        .minor     (minor),
        .digit     (digit)
    );

    assign first  = win_first(long_q, odd_q);
    assign last   = win_last(long_q, odd_q);
    assign in_win = (digit >= first) && (digit <= last);
    assign hit    = (minor == word_q) && (digit == first);

    // Next state and gate/status decode from the registered state.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        gate      = 1'b0;
        busy      = 1'b1;
        word_done = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (req) begin
                    load    = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                gate = hit;
                if (abort) begin
                    state_d = IDLE;
                end else if (hit) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                gate = in_win;
                if (abort) begin
                    state_d = IDLE;
                end else if (digit == last || !in_win) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                word_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_gate  = gate & ~wr_q;
    assign wr_gate  = gate & wr_q;
    assign ack      = ack_q;
    assign tank_sel = tank_q;

    // State register and the one-cycle acknowledge of a latch.
    always_ff @(posedge clk or negedge reset_neg) begin
        if (!reset_neg) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= load;
        end
    end

    // Capture the request fields; they stay put until the next request.
    always_ff @(posedge clk or negedge reset_neg) begin
        if (!reset_neg) begin
            wr_q   <= 1'b0;
            long_q <= 1'b0;
            odd_q  <= 1'b0;
            word_q <= '0;
            tank_q <= '0;
        end else if (load) begin
            wr_q   <= req_wr;
            long_q <= req_long;
            odd_q  <= req_addr[ADDR_ODD_BIT];
            word_q <= req_addr[ADDR_WORD_LSB +: MINOR_W];
            tank_q <= req_addr[ADDR_TANK_LSB +: TANK_W];
        end
    end

endmodule

// File: doc/tank_access_sequencer.md
Name: tank_access_sequencer

Overview:
Schedules one word transfer between main control and the mercury-delay-line store. It tracks the circulating word position (minor cycle) and the digit position, then opens the read or write gate of the addressed tank for exactly the digit window of the requested short or long word. It sits between the order/control stages (g12/g13 logic) and the tank in/out gating in the memory unit, and it serialises all store requests.

Parameters:
DIGITS, 36, digit positions per minor cycle (one long word incl. gap); must be even
WORDS, 16, long words circulating per tank
TANKS, 32, number of tanks
ADDR_W, 10, short-word address width = log2(TANKS)+log2(WORDS)+1

Ports:
clk  in  1  system clock, one digit time per cycle
reset_neg  in  1  asynchronous active-low reset
d0  in  1  digit-pulse generator marker for digit 0 of each minor cycle
req  in  1  transfer request, held until ack
req_wr  in  1  1 = write (store), 0 = read (fetch); sampled with req
req_long  in  1  1 = long word (addr bit 0 ignored)
req_addr  in  ADDR_W  [ADDR_W-1:5] tank, [4:1] long-word index, [0] odd short half
abort  in  1  synchronous abandon from starter/stop logic
ack  out  1  one-cycle pulse: request latched
busy  out  1  high from ack until done, inclusive of the done cycle
tank_sel  out  log2(TANKS)  latched tank number
rd_gate  out  1  tank output gate open (mob path to control)
wr_gate  out  1  tank input gate open (mib path from control)
word_done  out  1  one-cycle pulse after last gated digit
minor  out  log2(WORDS)  current long-word position
digit  out  log2(DIGITS)  current digit position

Behaviour:
- Reset: all outputs 0, digit=0, minor=0, state IDLE; effective immediately, gates drop mid-transfer.
- Digit counter: +1 per clk, wraps DIGITS-1 -> 0; when d0=1 forces digit to 0 in the next cycle (resync). Minor counter +1 (mod WORDS) on every digit wrap, not on a d0-forced resync unless digit was DIGITS-1.
- Window: long = digits 0..DIGITS-1; even short = 0..DIGITS/2-1; odd short = DIGITS/2..DIGITS-1.
- FSM IDLE: req=1 -> latch req_wr/req_long/req_addr, ack=1 same cycle the latch occurs (registered, visible next edge), busy=1, -> WAIT.
- WAIT: when minor==word index and digit==window start -> XFER; gate (rd or wr) asserted combinationally-from-register in the same cycles digit is inside window.
- XFER: gate high exactly for window length (DIGITS or DIGITS/2 cycles); on last window digit -> DONE.
- DONE: word_done=1 for one cycle, busy still 1, gates 0 -> IDLE. req present in DONE is not accepted until IDLE (next cycle).
- Latency ack-to-first-gate: 1 .. WORDS*DIGITS cycles; a request arriving exactly at window start in IDLE waits a full revolution.
- abort: any non-IDLE state -> IDLE next cycle, gates 0 next cycle, no word_done, busy 0.
- Never both rd_gate and wr_gate; tank_sel held stable from ack to IDLE.

Optional Feature:
TANK_SYNC_CHECK_EN: when defined, adds output sync_err (1 bit, sticky until reset) set if d0 arrives while digit != DIGITS-1 (timing slip). Without it no sync_err port exists and resync is silent.

Decomposition:
- Shared package edsac_mem_pkg: DIGITS/WORDS/TANKS constants, FSM state enum (IDLE, WAIT, XFER, DONE), address field slice constants.
- One sub-module: tank_position_counter (digit + minor counters with d0 resync, and sync check when enabled).

Test Plan:
- Reset then free-run 36*16 cycles with d0 every 36 -> minor wraps 15->0, digit 35->0, no gates.
- Read long, addr tank 3 word 5, req at minor 2 -> tank_sel=3, rd_gate high for 36 cycles while minor=5, word_done 1 cycle later.
- Write short odd half, word 0, req at minor 0 digit 20 -> waits to next revolution; wr_gate during digits 18..35 of minor 0 only.
- abort asserted mid XFER at digit 10 -> gate low next cycle, no word_done, busy 0, new req accepted.
- reset_neg low during XFER -> gates and busy 0 asynchronously; d0 early at digit 20 -> digit 0 next cycle, sync_err=1 with TANK_SYNC_CHECK_EN.
